// File: rtl/store_part_buffer.sv
// Store buffer between the M stage and memory: aligns store data onto byte
// lanes, flags misaligned/illegal stores and queues accepted stores in a FIFO.
module store_part_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  MemWriteM,
    input  logic [2:0]            StoreSrcM,
    input  logic [ADDR_WIDTH-1:0] ALUResultM,
    input  logic [31:0]           WriteDataM,
    output logic                  StallStoreM,
    output logic                  StoreFaultM,
    output logic                  BufEmptyM,
    output logic                  MemWValid,
    input  logic                  MemWReady,
    output logic [ADDR_WIDTH-1:0] MemWAddr,
    output logic [31:0]           MemWData,
    output logic [3:0]            MemWStrb
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic                  bad_store;
    logic                  enq;
    logic                  deq;
    logic [ADDR_WIDTH-3:0] ent_addr_d;
    logic [31:0]           ent_data_d;
    logic [3:0]            ent_strb_d;

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    // Payload storage is not reset; it is only observed while MemWValid is high.
    logic [ADDR_WIDTH-3:0] ent_addr_q [DEPTH];
    logic [31:0]           ent_data_q [DEPTH];
    logic [3:0]            ent_strb_q [DEPTH];

    always_comb begin
        bad_store  = 1'b0;
        ent_addr_d = ALUResultM[ADDR_WIDTH-1:2];
        ent_data_d = WriteDataM;
        ent_strb_d = 4'b1111;
        case (StoreSrcM)
            3'b000: begin
                ent_data_d = {4{WriteDataM[7:0]}};
                ent_strb_d = 4'b0001 << ALUResultM[1:0];
            end
            3'b001: begin
                bad_store  = ALUResultM[0];
                ent_data_d = {2{WriteDataM[15:0]}};
                ent_strb_d = ALUResultM[1] ? 4'b1100 : 4'b0011;
            end
            3'b010:  bad_store = |ALUResultM[1:0];
            default: bad_store = 1'b1;
        endcase
    end

    // Stall and valid come from registered count only, so no M-stage input
    // reaches the memory port combinationally.
    assign StoreFaultM = MemWriteM & bad_store;
    assign StallStoreM = (count_q == FULL_CNT);
    assign MemWValid   = (count_q != '0);
    assign BufEmptyM   = (count_q == '0);
    assign enq         = MemWriteM & ~bad_store & ~StallStoreM;
    assign deq         = MemWValid & MemWReady;

    always_comb begin
        wr_ptr_d = enq ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = deq ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            ent_addr_q[wr_ptr_q] <= ent_addr_d;
            ent_data_q[wr_ptr_q] <= ent_data_d;
            ent_strb_q[wr_ptr_q] <= ent_strb_d;
        end
    end

    assign MemWAddr = {ent_addr_q[rd_ptr_q], 2'b00};
    assign MemWData = ent_data_q[rd_ptr_q];
    assign MemWStrb = ent_strb_q[rd_ptr_q];

endmodule

// File: tb/tb_store_part_buffer.sv
// Scoreboard bench for store_part_buffer: a byte-lane reference model pushes
// expected memory writes, a negedge monitor pops them on each handshake.
module tb_store_part_buffer;
    localparam int AW    = 32;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          MemWriteM = 1'b0;
    logic [2:0]    StoreSrcM = 3'b000;
    logic [AW-1:0] ALUResultM = '0;
    logic [31:0]   WriteDataM = '0;
    logic          StallStoreM, StoreFaultM, BufEmptyM, MemWValid;
    logic          MemWReady = 1'b0;
    logic [AW-1:0] MemWAddr;
    logic [31:0]   MemWData;
    logic [3:0]    MemWStrb;

    int   n_chk  = 0;
    int   n_fail = 0;
    ent_t exp_q[$];

    store_part_buffer #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .MemWriteM(MemWriteM), .StoreSrcM(StoreSrcM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .StallStoreM(StallStoreM),
        .StoreFaultM(StoreFaultM), .BufEmptyM(BufEmptyM), .MemWValid(MemWValid),
        .MemWReady(MemWReady), .MemWAddr(MemWAddr), .MemWData(MemWData),
        .MemWStrb(MemWStrb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_fault(input logic we, input logic [2:0] src, input logic [31:0] a);
        int size;
        if (!we) return 1'b0;
        if (src > 3'd2) return 1'b1;
        size = 1 << src;
        return (a % size) != 0;
    endfunction

    // Byte-level view: a store of 'size' bytes covers lanes [off, off+size),
    // and every lane carries the store's byte (lane mod size).
    function automatic ent_t model_ent(input logic [2:0] src, input logic [31:0] a,
                                       input logic [31:0] wd);
        ent_t e;
        int size, off;
        size   = 1 << src;
        off    = (a % 4) / size * size;
        e.addr = a - (a % 4);
        e.data = '0;
        e.strb = '0;
        for (int i = 0; i < 4; i++) begin
            e.data[8*i +: 8] = wd[8*(i % size) +: 8];
            e.strb[i]        = (i >= off) && (i < off + size);
        end
        return e;
    endfunction

    // Monitor: compares outputs against the model state, then advances the
    // model to what the coming rising edge should do.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                bit f, enq, deq;
                f = is_fault(MemWriteM, StoreSrcM, ALUResultM);
                chk("fault",  StoreFaultM, f);
                chk("valid",  MemWValid, exp_q.size() != 0);
                chk("stall",  StallStoreM, exp_q.size() == DEPTH);
                chk("empty",  BufEmptyM, exp_q.size() == 0);
                if (exp_q.size() != 0 && MemWValid) begin
                    chk("addr", MemWAddr, exp_q[0].addr);
                    chk("data", MemWData, exp_q[0].data);
                    chk("strb", MemWStrb, exp_q[0].strb);
                end
                enq = MemWriteM && !f && exp_q.size() < DEPTH;
                deq = exp_q.size() != 0 && MemWReady;
                if (deq) void'(exp_q.pop_front());
                if (enq) exp_q.push_back(model_ent(StoreSrcM, ALUResultM, WriteDataM));
            end
        end
    end

    task automatic step(input logic we, input logic [2:0] src, input logic [31:0] a,
                        input logic [31:0] wd, input logic rdy);
        @(posedge clk);
        #1;
        MemWriteM  = we;
        StoreSrcM  = src;
        ALUResultM = a;
        WriteDataM = wd;
        MemWReady  = rdy;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 3'b000, 32'h0, 32'h0, rdy);
    endtask

    initial begin
        #1;
        chk("rst_valid", MemWValid, 1'b0);
        chk("rst_stall", StallStoreM, 1'b0);
        chk("rst_empty", BufEmptyM, 1'b1);
        MemWriteM = 1'b1; StoreSrcM = 3'b010; ALUResultM = 32'h3;
        #1;
        chk("rst_fault", StoreFaultM, 1'b1);
        MemWriteM = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Byte store with immediate drain, then halfword/word lane mapping.
        step(1'b1, 3'b000, 32'h1003, 32'h000000A5, 1'b1);
        idle(1'b1);
        idle(1'b1);
        step(1'b1, 3'b001, 32'h2002, 32'h1234BEEF, 1'b1);
        step(1'b1, 3'b010, 32'h2004, 32'hCAFEF00D, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Faulting stores never enter the queue.
        step(1'b1, 3'b001, 32'h2001, 32'h11111111, 1'b1);
        step(1'b1, 3'b010, 32'h2006, 32'h22222222, 1'b1);
        step(1'b1, 3'b011, 32'h2000, 32'h33333333, 1'b1);
        idle(1'b1);

        // Fill while memory is stalled, hold the 5th store, then release.
        for (int i = 0; i < 5; i++)
            step(1'b1, 3'b010, 32'h3000 + 4*i, 32'hA0000000 + i, 1'b0);
        repeat (3) step(1'b1, 3'b010, 32'h3010, 32'hA0000004, 1'b0);
        step(1'b1, 3'b010, 32'h3010, 32'hA0000004, 1'b1);
        step(1'b1, 3'b010, 32'h3010, 32'hA0000004, 1'b1);
        repeat (6) idle(1'b1);

        // Reset between edges with three stores queued discards them.
        for (int i = 0; i < 3; i++)
            step(1'b1, 3'b000, 32'h5000 + i, 32'h000000C0 + i, 1'b0);
        idle(1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", MemWValid, 1'b0);
        chk("midrst_empty", BufEmptyM, 1'b1);
        exp_q.delete();
        #1 rst_n = 1'b1;
        repeat (3) idle(1'b1);

        // Random traffic, including same-word stores and backpressure.
        for (int n = 0; n < 400; n++) begin
            int r;
            logic [2:0] src;
            r = $urandom_range(0, 9);
            if (r < 3)      src = 3'b000;
            else if (r < 6) src = 3'b001;
            else if (r < 9) src = 3'b010;
            else            src = 3'($urandom_range(3, 7));
            step($urandom_range(0, 9) < 7, src, 32'h4000 + $urandom_range(0, 15),
                 $urandom, $urandom_range(0, 1) == 1);
        end

        for (int n = 0; n < 20 && exp_q.size() != 0; n++) idle(1'b1);
        idle(1'b1);
        chk("drain_done", exp_q.size(), 0);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
